// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and DLX encodings for the ALU issue stage
//
// Purpose: ALU operation codes, DLX opcode/func encodings, the issue-slot
// entry layout and the skid-buffer state type used by alu_decode and
// alu_issue_stage.
// Ports: none (package).

package alu_pkg;

  typedef enum logic [4:0] {
    ALU_LHI    = 5'd0,   // op2 << 16
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_AND    = 5'd3,
    ALU_OR     = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SLL    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SEL_Z  = 5'd8,   // op2 when op1 == 0
    ALU_SEL_NZ = 5'd9,   // op2 when op1 != 0
    ALU_SEQ    = 5'd10,
    ALU_SLE    = 5'd11,
    ALU_SLT    = 5'd12,
    ALU_SNE    = 5'd13,
    ALU_SRA    = 5'd14,
    ALU_LINK   = 5'd15,  // op1 + 4
    ALU_BR_Z   = 5'd16,  // op2 when op1 == 0, else 4
    ALU_BR_NZ  = 5'd17   // op2 when op1 != 0, else 4
  } alu_op_e;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQZ  = 6'h04;
  localparam logic [5:0] OPC_BNEZ  = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SUBI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LHI   = 6'h0F;
  localparam logic [5:0] OPC_JR    = 6'h12;
  localparam logic [5:0] OPC_JALR  = 6'h13;
  localparam logic [5:0] OPC_SLLI  = 6'h14;
  localparam logic [5:0] OPC_SRLI  = 6'h16;
  localparam logic [5:0] OPC_SRAI  = 6'h17;
  localparam logic [5:0] OPC_SEQI  = 6'h18;
  localparam logic [5:0] OPC_SNEI  = 6'h19;
  localparam logic [5:0] OPC_SLTI  = 6'h1A;
  localparam logic [5:0] OPC_SLEI  = 6'h1C;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FUNC_SLL = 6'h04;
  localparam logic [5:0] FUNC_SRL = 6'h06;
  localparam logic [5:0] FUNC_SRA = 6'h07;
  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_XOR = 6'h26;
  localparam logic [5:0] FUNC_SEQ = 6'h28;
  localparam logic [5:0] FUNC_SNE = 6'h29;
  localparam logic [5:0] FUNC_SLT = 6'h2A;
  localparam logic [5:0] FUNC_SLE = 6'h2C;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_RESET = '{
    alu_op:  ALU_LHI,
    op1:     32'd0,
    op2:     32'd0,
    rd:      5'd0,
    wb_en:   1'b0,
    illegal: 1'b0
  };

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,  // main and skid invalid
    BUF_ONE   = 2'd1,  // main valid
    BUF_FULL  = 2'd2   // main and skid valid
  } buf_state_e;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational DLX instruction to ALU issue entry decoder
//
// Purpose: maps one instruction word, its pc and the two register-file read
// values onto ALU op code, operands, destination register and write-back
// enable. Undecodable words become an ADD 0,0 with no write-back.
// Optional: ALU_ISSUE_ILLEGAL_EN flags such words in the entry's illegal bit;
// without it the bit is constant 0.
// Ports:
//   i_instr    in  32  instruction word
//   i_pc       in  32  address of i_instr
//   i_rs1_val  in  32  value of register instr[25:21]
//   i_rs2_val  in  32  value of register instr[20:16]
//   o_entry    out     decoded issue_entry_t

module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]  i_instr,
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_rs1_val,
  input  logic [31:0]  i_rs2_val,
  output issue_entry_t o_entry
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_func;
  logic [31:0] w_sext16;
  logic [31:0] w_zext16;
  logic [31:0] w_sext26;

  assign w_opcode = i_instr[31:26];
  assign w_func   = i_instr[5:0];
  assign w_sext16 = {{16{i_instr[15]}}, i_instr[15:0]};
  assign w_zext16 = {16'd0, i_instr[15:0]};
  assign w_sext26 = {{6{i_instr[25]}}, i_instr[25:0]};

  alu_op_e     w_op;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [4:0]  w_rd;
  logic        w_wb_en;
  logic        w_bad;
  logic        w_is_imm;  // I-type ALU or load: rs1 op imm16 -> instr[20:16]
  logic        w_zext;    // logical ops and shifts take an unsigned immediate

  always_comb begin
    w_op     = ALU_ADD;
    w_op1    = 32'd0;
    w_op2    = 32'd0;
    w_rd     = 5'd0;
    w_wb_en  = 1'b0;
    w_bad    = 1'b0;
    w_is_imm = 1'b0;
    w_zext   = 1'b0;

    case (w_opcode)
      OPC_RTYPE: begin
        w_op1   = i_rs1_val;
        w_op2   = i_rs2_val;
        w_rd    = i_instr[15:11];
        w_wb_en = 1'b1;
        case (w_func)
          FUNC_ADD: w_op = ALU_ADD;
          FUNC_SUB: w_op = ALU_SUB;
          FUNC_AND: w_op = ALU_AND;
          FUNC_OR:  w_op = ALU_OR;
          FUNC_XOR: w_op = ALU_XOR;
          FUNC_SLL: w_op = ALU_SLL;
          FUNC_SRL: w_op = ALU_SRL;
          FUNC_SRA: w_op = ALU_SRA;
          FUNC_SEQ: w_op = ALU_SEQ;
          FUNC_SNE: w_op = ALU_SNE;
          FUNC_SLT: w_op = ALU_SLT;
          FUNC_SLE: w_op = ALU_SLE;
          default:  w_bad = 1'b1;
        endcase
      end
      OPC_ADDI: begin w_is_imm = 1'b1; w_op = ALU_ADD; end
      OPC_SUBI: begin w_is_imm = 1'b1; w_op = ALU_SUB; end
      OPC_ANDI: begin w_is_imm = 1'b1; w_zext = 1'b1; w_op = ALU_AND; end
      OPC_ORI:  begin w_is_imm = 1'b1; w_zext = 1'b1; w_op = ALU_OR;  end
      OPC_XORI: begin w_is_imm = 1'b1; w_zext = 1'b1; w_op = ALU_XOR; end
      OPC_LHI:  begin w_is_imm = 1'b1; w_zext = 1'b1; w_op = ALU_LHI; end
      OPC_SLLI: begin w_is_imm = 1'b1; w_zext = 1'b1; w_op = ALU_SLL; end
      OPC_SRLI: begin w_is_imm = 1'b1; w_zext = 1'b1; w_op = ALU_SRL; end
      OPC_SRAI: begin w_is_imm = 1'b1; w_zext = 1'b1; w_op = ALU_SRA; end
      OPC_SEQI: begin w_is_imm = 1'b1; w_op = ALU_SEQ; end
      OPC_SNEI: begin w_is_imm = 1'b1; w_op = ALU_SNE; end
      OPC_SLTI: begin w_is_imm = 1'b1; w_op = ALU_SLT; end
      OPC_SLEI: begin w_is_imm = 1'b1; w_op = ALU_SLE; end
      OPC_LW:   begin w_is_imm = 1'b1; w_op = ALU_ADD; end
      OPC_SW: begin
        // address computation only; no destination
        w_op1 = i_rs1_val;
        w_op2 = w_sext16;
      end
      OPC_BEQZ: begin
        w_op  = ALU_BR_Z;
        w_op1 = i_rs1_val;
        w_op2 = w_sext16;
      end
      OPC_BNEZ: begin
        w_op  = ALU_BR_NZ;
        w_op1 = i_rs1_val;
        w_op2 = w_sext16;
      end
      OPC_J: begin
        w_op1 = i_pc + 32'd4;
        w_op2 = w_sext26;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU produces the return address pc+4 for r31
        w_op    = ALU_LINK;
        w_op1   = i_pc;
        w_rd    = LINK_REG;
        w_wb_en = 1'b1;
      end
      OPC_JR: begin
        w_op1 = i_rs1_val;
      end
      default: w_bad = 1'b1;
    endcase

    if (w_is_imm) begin
      w_op1   = i_rs1_val;
      w_op2   = w_zext ? w_zext16 : w_sext16;
      w_rd    = i_instr[20:16];
      w_wb_en = 1'b1;
    end

    // undecodable words leave as a harmless ADD 0,0 with no write-back
    if (w_bad) begin
      w_op    = ALU_ADD;
      w_op1   = 32'd0;
      w_op2   = 32'd0;
      w_rd    = 5'd0;
      w_wb_en = 1'b0;
    end
  end

  assign o_entry.alu_op = w_op;
  assign o_entry.op1    = w_op1;
  assign o_entry.op2    = w_op2;
  assign o_entry.rd     = w_rd;
  assign o_entry.wb_en  = w_wb_en;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign o_entry.illegal = w_bad;
`else
  assign o_entry.illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - DLX decode/issue stage with registered ID/EX slot and skid buffer
//
// Purpose: decodes each accepted instruction and holds it in a valid/ready
// issue slot feeding the ALU. A one-entry skid register lets in_ready come
// straight from a flop while still absorbing one cycle of execute stall.
// Optional: ALU_ISSUE_ILLEGAL_EN (see alu_decode) drives out_illegal.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   flush                drop all held entries
//   in_valid/in_ready    upstream handshake (in_ready registered)
//   in_instr, in_pc      instruction word and its address
//   in_rs1_val/rs2_val   register-file read values
//   out_valid/out_ready  execute handshake
//   out_alu_op..illegal  decoded contents of the issue slot

module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_alu_op,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_illegal
);

  issue_entry_t w_dec;

  alu_decode u_decode (
    .i_instr   (in_instr),
    .i_pc      (in_pc),
    .i_rs1_val (in_rs1_val),
    .i_rs2_val (in_rs2_val),
    .o_entry   (w_dec)
  );

  buf_state_e   r_state;
  buf_state_e   w_state_nxt;
  logic         r_in_ready;
  issue_entry_t r_main;
  issue_entry_t r_skid;

  logic w_accept;
  logic w_load_main_dec;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_accept = in_valid & r_in_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_dec  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    if (flush) begin
      // any concurrent accept is dropped; a concurrent consume needs no action
      w_state_nxt = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_accept) begin
            w_state_nxt     = BUF_ONE;
            w_load_main_dec = 1'b1;
          end
        end
        BUF_ONE: begin
          if (w_accept && out_ready) begin
            w_load_main_dec = 1'b1;
          end else if (w_accept) begin
            // main is stalled: park the newcomer behind it
            w_state_nxt = BUF_FULL;
            w_load_skid = 1'b1;
          end else if (out_ready) begin
            w_state_nxt = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          // in_ready is low here, so nothing new can arrive this cycle
          if (out_ready) begin
            w_state_nxt      = BUF_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BUF_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != BUF_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= ENTRY_RESET;
      r_skid <= ENTRY_RESET;
    end else begin
      if (w_load_main_dec) begin
        r_main <= w_dec;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != BUF_EMPTY);
  assign out_alu_op  = r_main.alu_op;
  assign out_op1     = r_main.op1;
  assign out_op2     = r_main.op2;
  assign out_rd      = r_main.rd;
  assign out_wb_en   = r_main.wb_en;
  assign out_illegal = r_main.illegal;

endmodule
